// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among N byte producers.
// Round-robin grant, one byte per grant. With TAG_EN, each data byte is
// preceded by a tag byte 8'h80|id. A missing busy-rise from uart_tx is
// caught by a timeout; the offending byte is dropped and err pulses.
module uart_tx_arbiter #(
  parameter int N          = 4,
  parameter int TAG_EN     = 0,
  parameter int HI_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  input  logic           tx_busy,
  output logic [3:0]     grant_id,
  output logic           active,
  output logic           err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (HI_TIMEOUT > 1) ? $clog2(HI_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   ptr_r, ptr_s;
  logic [7:0]      byte_r, byte_s;
  logic [7:0]      tx_data_r, tx_data_s;
  logic [3:0]      grant_id_r, grant_id_s;
  logic            tx_start_r, tx_start_s;
  logic            err_r, err_s;
  logic            phase_r, phase_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [N-1:0]    req_ready_s;
  logic            win_found_s;
  logic [PW-1:0]   win_idx_s;

  // Round-robin search: first valid requester at or above ptr, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 0; i < N; i++) begin
      if (!win_found_s && req_valid[(int'(ptr_r) + i) % N]) begin
        win_found_s = 1'b1;
        win_idx_s   = PW'((int'(ptr_r) + i) % N);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and next-output logic for the grant/launch/handshake FSM.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    byte_s      = byte_r;
    tx_data_s   = tx_data_r;
    grant_id_s  = grant_id_r;
    tx_start_s  = 1'b0;
    err_s       = 1'b0;
    phase_s     = phase_r;
    cnt_s       = cnt_r;
    req_ready_s = '0;
    case (state_r)
      IDLE: begin
        if (!tx_busy && win_found_s) begin
          req_ready_s[win_idx_s] = 1'b1;
          byte_s     = req_data[8*int'(win_idx_s) +: 8];
          grant_id_s = 4'(win_idx_s);
          if (int'(win_idx_s) == N - 1) begin
            ptr_s = '0;
          end else begin
            ptr_s = win_idx_s + PW'(1);
          end
          phase_s    = 1'b0;
          tx_start_s = 1'b1;
          if (TAG_EN != 0) begin
            tx_data_s = 8'h80 | {4'h0, 4'(win_idx_s)};
          end else begin
            tx_data_s = req_data[8*int'(win_idx_s) +: 8];
          end
          state_s = LAUNCH;
        end else begin
          state_s = IDLE;
        end
      end
      LAUNCH: begin
        cnt_s   = '0;
        state_s = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_s = WAIT_LO;
        end else if (cnt_r == CW'(HI_TIMEOUT - 1)) begin
          // uart_tx never acknowledged: drop the byte and flag it.
          err_s   = 1'b1;
          phase_s = 1'b0;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      WAIT_LO: begin
        if (tx_busy) begin
          state_s = WAIT_LO;
        end else if ((TAG_EN != 0) && !phase_r) begin
          // Tag byte done; launch the data byte itself.
          phase_s    = 1'b1;
          tx_start_s = 1'b1;
          tx_data_s  = byte_r;
          state_s    = LAUNCH;
        end else begin
          phase_s = 1'b0;
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= '0;
      byte_r     <= 8'h00;
      tx_data_r  <= 8'h00;
      grant_id_r <= 4'h0;
      tx_start_r <= 1'b0;
      err_r      <= 1'b0;
      phase_r    <= 1'b0;
      cnt_r      <= '0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      byte_r     <= byte_s;
      tx_data_r  <= tx_data_s;
      grant_id_r <= grant_id_s;
      tx_start_r <= tx_start_s;
      err_r      <= err_s;
      phase_r    <= phase_s;
      cnt_r      <= cnt_s;
    end
  end

  // Acceptance is combinational so the producer sees it in the grant cycle.
  assign req_ready = rst ? '0 : req_ready_s;
  assign tx_start  = tx_start_r;
  assign tx_data   = tx_data_r;
  assign grant_id  = grant_id_r;
  assign err       = err_r;
  assign active    = (state_r != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a plain instance (TAG_EN=0) and a tagged
// instance (TAG_EN=1), each attached to a small uart_tx busy stub.
module tb_uart_tx_arbiter;

  logic        clk, rst;
  logic [3:0]  req_valid, req_ready, grant_id;
  logic [31:0] req_data;
  logic        tx_start, tx_busy, active, err;
  logic [7:0]  tx_data;
  logic [3:0]  req_valid_t, req_ready_t, grant_id_t;
  logic [31:0] req_data_t;
  logic        tx_start_t, tx_busy_t, active_t, err_t;
  logic [7:0]  tx_data_t;

  logic stub_mode, force_busy;
  int   sctr, sctr_t;
  int   checks, errors;
  int   bad_start, rdy_pulses_t;

  uart_tx_arbiter #(.N(4), .TAG_EN(0), .HI_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_id(grant_id), .active(active), .err(err));

  uart_tx_arbiter #(.N(4), .TAG_EN(1), .HI_TIMEOUT(15)) dut_t (
    .clk(clk), .rst(rst), .req_valid(req_valid_t), .req_data(req_data_t),
    .req_ready(req_ready_t), .tx_start(tx_start_t), .tx_data(tx_data_t),
    .tx_busy(tx_busy_t), .grant_id(grant_id_t), .active(active_t), .err(err_t));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // uart_tx stub: busy rises 2 cycles after a start and stays high 4 cycles.
  always @(posedge clk) begin
    if (rst) sctr <= 0;
    else if (tx_start) sctr <= 1;
    else if (sctr != 0 && sctr < 6) sctr <= sctr + 1;
    else sctr <= 0;
  end
  assign tx_busy = stub_mode ? (sctr >= 2 && sctr <= 5) : force_busy;

  // Same stub for the tagged instance.
  always @(posedge clk) begin
    if (rst) sctr_t <= 0;
    else if (tx_start_t) sctr_t <= 1;
    else if (sctr_t != 0 && sctr_t < 6) sctr_t <= sctr_t + 1;
    else sctr_t <= 0;
  end
  assign tx_busy_t = (sctr_t >= 2 && sctr_t <= 5);

  // Protocol monitors.
  always @(posedge clk) begin
    if (tx_start && tx_busy) bad_start <= bad_start + 1;
    if (req_ready_t != 4'h0) rdy_pulses_t <= rdy_pulses_t + 1;
  end

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic [7:0]  exp_data;
    logic [3:0]  exp_gid;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Polls (starting right now) for a grant on the plain instance.
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req_ready != 4'h0) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (!active) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    bit ok, seen, saw_busy;
    int k, nstart;
    logic [3:0] exp_rr[5];
    checks = 0; errors = 0; bad_start = 0; rdy_pulses_t = 0;
    rst = 1'b1; stub_mode = 1'b1; force_busy = 1'b0;
    req_valid = 4'b0100; req_data = 32'h13121110;
    req_valid_t = 4'h0; req_data_t = 32'h0;

    vecs[0]  = '{4'b0100, 32'h00030000, 4'b0100, 8'h03, 4'd2};
    vecs[1]  = '{4'b1111, 32'h13121110, 4'b1000, 8'h13, 4'd3};
    vecs[2]  = '{4'b1111, 32'h13121110, 4'b0001, 8'h10, 4'd0};
    vecs[3]  = '{4'b1111, 32'h13121110, 4'b0010, 8'h11, 4'd1};
    vecs[4]  = '{4'b1111, 32'h13121110, 4'b0100, 8'h12, 4'd2};
    vecs[5]  = '{4'b1111, 32'h13121110, 4'b1000, 8'h13, 4'd3};
    vecs[6]  = '{4'b1111, 32'hA5B6C7D8, 4'b0001, 8'hD8, 4'd0};
    vecs[7]  = '{4'b0001, 32'h13121110, 4'b0001, 8'h10, 4'd0};
    vecs[8]  = '{4'b1001, 32'hEE0000FF, 4'b1000, 8'hEE, 4'd3};
    vecs[9]  = '{4'b0110, 32'h00445500, 4'b0010, 8'h55, 4'd1};
    vecs[10] = '{4'b0011, 32'h00006677, 4'b0001, 8'h77, 4'd0};

    // Reset values, with a request pending during reset.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
    chk("rst_grant_id", {28'd0, grant_id}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'h0;

    // Table-driven single grants: winner, launch timing, byte, id.
    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      req_valid = vecs[v].valid;
      req_data  = vecs[v].data;
      wait_ready(ok);
      chk($sformatf("v%0d_grant_seen", v), {31'd0, ok}, 32'd1);
      chk($sformatf("v%0d_req_ready", v), {28'd0, req_ready}, {28'd0, vecs[v].exp_ready});
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_ready_drop", v), {28'd0, req_ready}, 32'd0);
      chk($sformatf("v%0d_tx_start", v), {31'd0, tx_start}, 32'd1);
      chk($sformatf("v%0d_tx_data", v), {24'd0, tx_data}, {24'd0, vecs[v].exp_data});
      chk($sformatf("v%0d_grant_id", v), {28'd0, grant_id}, {28'd0, vecs[v].exp_gid});
      req_valid = 4'h0;
      wait_idle(ok);
      chk($sformatf("v%0d_idle", v), {31'd0, ok}, 32'd1);
      chk($sformatf("v%0d_busy_low_at_idle", v), {31'd0, tx_busy}, 32'd0);
    end

    // Tagged instance: tag byte, then data byte after busy falls.
    @(negedge clk);
    req_valid_t = 4'b1000;
    req_data_t  = 32'h5A000000;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if (req_ready_t != 4'h0) seen = 1'b1;
      else @(negedge clk);
    end
    chk("tag_req_ready", {28'd0, req_ready_t}, 32'h8);
    @(negedge clk);
    #1;
    chk("tag_start1", {31'd0, tx_start_t}, 32'd1);
    chk("tag_data1", {24'd0, tx_data_t}, 32'h83);
    chk("tag_gid", {28'd0, grant_id_t}, 32'd3);
    req_valid_t = 4'h0;
    seen = 1'b0; saw_busy = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (tx_busy_t) saw_busy = 1'b1;
      if (tx_start_t) seen = 1'b1;
    end
    chk("tag_start2_seen", {31'd0, seen}, 32'd1);
    chk("tag_data2", {24'd0, tx_data_t}, 32'h5A);
    chk("tag_busy_between", {31'd0, saw_busy}, 32'd1);
    chk("tag_busy_low_at_start2", {31'd0, tx_busy_t}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (!active_t) seen = 1'b1;
    end
    chk("tag_idle", {31'd0, seen}, 32'd1);
    chk("tag_ready_pulses", rdy_pulses_t, 32'd1);

    // Held requests from reset: order 0,1,2,3,0.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad_start = 0;
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    for (int g = 0; g < 5; g++) begin
      wait_ready(ok);
      chk($sformatf("rr%0d_ready", g), {28'd0, req_ready}, {28'd0, exp_rr[g]});
      @(negedge clk);
    end
    req_valid = 4'h0;
    wait_idle(ok);
    chk("rr_idle", {31'd0, ok}, 32'd1);
    chk("rr_no_start_while_busy", bad_start, 32'd0);

    // Busy-rise timeout: ptr=1 now, so requester 2 wins.
    @(negedge clk);
    stub_mode = 1'b0; force_busy = 1'b0;
    req_valid = 4'b0100;
    wait_ready(ok);
    chk("to_ready", {28'd0, req_ready}, 32'h4);
    @(negedge clk);
    #1;
    chk("to_start", {31'd0, tx_start}, 32'd1);
    req_valid = 4'h0;
    k = 0;
    for (int i = 1; i <= 30 && k == 0; i++) begin
      @(negedge clk);
      #1;
      if (err) k = i;
    end
    chk("to_err_delay", k, 32'd16);
    chk("to_idle", {31'd0, active}, 32'd0);
    @(negedge clk);
    #1;
    chk("to_err_pulse", {31'd0, err}, 32'd0);
    stub_mode = 1'b1;
    req_valid = 4'b1000;
    wait_ready(ok);
    chk("to_next_ready", {28'd0, req_ready}, 32'h8);
    @(negedge clk);
    #1;
    chk("to_next_data", {24'd0, tx_data}, 32'h13);
    req_valid = 4'h0;
    wait_idle(ok);
    chk("to_next_idle", {31'd0, ok}, 32'd1);

    // External busy blocks granting.
    @(negedge clk);
    stub_mode = 1'b0; force_busy = 1'b1;
    req_valid = 4'b0001;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (req_ready != 4'h0) seen = 1'b1;
    end
    chk("busy_blocks_grant", {31'd0, seen}, 32'd0);
    force_busy = 1'b0;
    #1;
    chk("busy_release_ready", {28'd0, req_ready}, 32'h1);
    @(negedge clk);
    #1;
    chk("mid_start", {31'd0, tx_start}, 32'd1);
    req_valid = 4'h0;
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_active", {31'd0, active}, 32'd1);

    // Reset while in WAIT_LO.
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_start", {31'd0, tx_start}, 32'd0);
    chk("mid_rst_data", {24'd0, tx_data}, 32'h00);
    chk("mid_rst_gid", {28'd0, grant_id}, 32'd0);
    chk("mid_rst_active", {31'd0, active}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    force_busy = 1'b0;
    nstart = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (tx_start) nstart++;
    end
    chk("mid_no_resend", nstart, 32'd0);
    stub_mode = 1'b1;
    req_valid = 4'b1001;
    wait_ready(ok);
    chk("mid_ptr_zero", {28'd0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 4'h0;
    wait_idle(ok);
    chk("final_idle", {31'd0, ok}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
